// File: rtl/sap_pkg.sv
// Shared constants for the SAP controller-sequencer: opcodes, control-word
// bit positions and one-hot T-state encodings.
package sap_pkg;

   localparam int OPCODE_W   = 4;
   localparam int CTRL_WIDTH = 12;
   localparam int T_STATES   = 6;

   localparam logic [OPCODE_W-1:0] OP_LDA = 4'h0;
   localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
   localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
   localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
   localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

   localparam int CTRL_PC_INC   = 11;
   localparam int CTRL_PC_OUT   = 10;
   localparam int CTRL_MAR_LOAD = 9;
   localparam int CTRL_RAM_OUT  = 8;
   localparam int CTRL_IR_LOAD  = 7;
   localparam int CTRL_IR_OUT   = 6;
   localparam int CTRL_A_LOAD   = 5;
   localparam int CTRL_A_OUT    = 4;
   localparam int CTRL_ALU_SUB  = 3;
   localparam int CTRL_ALU_OUT  = 2;
   localparam int CTRL_B_LOAD   = 1;
   localparam int CTRL_OUT_LOAD = 0;

   // Signals that drive the shared bus; at most one may be active per cycle.
   localparam logic [CTRL_WIDTH-1:0] CTRL_BUS_MASK = 12'h554;

   localparam logic [T_STATES-1:0] T1 = 6'b000001;
   localparam logic [T_STATES-1:0] T2 = 6'b000010;
   localparam logic [T_STATES-1:0] T3 = 6'b000100;
   localparam logic [T_STATES-1:0] T4 = 6'b001000;
   localparam logic [T_STATES-1:0] T5 = 6'b010000;
   localparam logic [T_STATES-1:0] T6 = 6'b100000;

endpackage

// File: rtl/ring_counter.sv
// One-hot ring counter: synchronous active-low clear to bit 0, advances
// when enabled and not held.
module ring_counter #(
   parameter int N = 6
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         en,
   input  logic         hold,
   output logic [N-1:0] q
);

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         q <= {{(N-1){1'b0}}, 1'b1};
      end else if (en && !hold) begin
         q <= {q[N-2:0], q[N-1]};
      end
   end

endmodule

// File: rtl/sap_controller.sv
// SAP CPU controller-sequencer: T1..T6 ring plus HALT flag, with the control
// word decoded combinationally from the held T-state and the IR opcode.
//
// state | meaning
// T1    | fetch: PC onto bus, load MAR
// T2    | fetch: increment PC
// T3    | fetch: RAM onto bus, load IR
// T4    | execute step 1 (HLT enters HALT from here)
// T5    | execute step 2
// T6    | execute step 3, then back to T1
// HALT  | absorbing, ctrl=0, t_state frozen at T4, left only via clr_n
module sap_controller
   import sap_pkg::*;
#(
   parameter int OPCODE_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    clr_n,
   input  logic                    i_en,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   output logic [CTRL_WIDTH-1:0]   ctrl,
   output logic [T_STATES-1:0]     t_state,
   output logic                    halted
);

   logic halt_entry;
   logic [CTRL_WIDTH-1:0] ctrl_c;

   assign halt_entry = (t_state == T4) && (opcode == OPCODE_WIDTH'(OP_HLT)) && !halted;

   ring_counter #(.N(T_STATES)) u_ring (
      .clk   (clk),
      .clr_n (clr_n),
      .en    (i_en),
      .hold  (halted | halt_entry),
      .q     (t_state)
   );

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         halted <= 1'b0;
      end else if (i_en && halt_entry) begin
         halted <= 1'b1;
      end
   end

   // Reset, pause and HALT all gate the whole word so no register loads.
   always_comb begin
      ctrl_c = '0;
      if (clr_n && i_en && !halted) begin
         case (t_state)
            T1: begin
               ctrl_c[CTRL_PC_OUT]   = 1'b1;
               ctrl_c[CTRL_MAR_LOAD] = 1'b1;
            end
            T2: ctrl_c[CTRL_PC_INC] = 1'b1;
            T3: begin
               ctrl_c[CTRL_RAM_OUT] = 1'b1;
               ctrl_c[CTRL_IR_LOAD] = 1'b1;
            end
            T4: begin
               case (opcode)
                  OPCODE_WIDTH'(OP_LDA), OPCODE_WIDTH'(OP_ADD), OPCODE_WIDTH'(OP_SUB): begin
                     ctrl_c[CTRL_IR_OUT]   = 1'b1;
                     ctrl_c[CTRL_MAR_LOAD] = 1'b1;
                  end
                  OPCODE_WIDTH'(OP_OUT): begin
                     ctrl_c[CTRL_A_OUT]    = 1'b1;
                     ctrl_c[CTRL_OUT_LOAD] = 1'b1;
                  end
                  default: ctrl_c = '0;
               endcase
            end
            T5: begin
               case (opcode)
                  OPCODE_WIDTH'(OP_LDA): begin
                     ctrl_c[CTRL_RAM_OUT] = 1'b1;
                     ctrl_c[CTRL_A_LOAD]  = 1'b1;
                  end
                  OPCODE_WIDTH'(OP_ADD), OPCODE_WIDTH'(OP_SUB): begin
                     ctrl_c[CTRL_RAM_OUT] = 1'b1;
                     ctrl_c[CTRL_B_LOAD]  = 1'b1;
                     ctrl_c[CTRL_ALU_SUB] = (opcode == OPCODE_WIDTH'(OP_SUB));
                  end
                  default: ctrl_c = '0;
               endcase
            end
            T6: begin
               if (opcode == OPCODE_WIDTH'(OP_ADD) || opcode == OPCODE_WIDTH'(OP_SUB)) begin
                  ctrl_c[CTRL_ALU_OUT] = 1'b1;
                  ctrl_c[CTRL_A_LOAD]  = 1'b1;
                  ctrl_c[CTRL_ALU_SUB] = (opcode == OPCODE_WIDTH'(OP_SUB));
               end
            end
            default: ctrl_c = '0;
         endcase
      end
   end

   assign ctrl = ctrl_c;

endmodule

// File: tb/tb_sap_controller.sv
// Directed bench for sap_controller: fetch/execute words per opcode, pause,
// reset, HALT, plus a randomised NOP/bus-driver sweep against a small table.
module tb_sap_controller;
   import sap_pkg::*;

   logic        clk = 1'b0;
   logic        clr_n = 1'b0;
   logic        i_en = 1'b1;
   logic [3:0]  opcode = 4'h0;
   logic [11:0] ctrl;
   logic [5:0]  t_state;
   logic        halted;

   int checks = 0;
   int failures = 0;

   sap_controller #(.OPCODE_WIDTH(4)) dut (
      .clk     (clk),
      .clr_n   (clr_n),
      .i_en    (i_en),
      .opcode  (opcode),
      .ctrl    (ctrl),
      .t_state (t_state),
      .halted  (halted)
   );

   always #5 clk = ~clk;

   // Expected control word for T-state index 0..5 and opcode, when enabled.
   function automatic logic [11:0] exp_word(input int idx, input logic [3:0] op);
      case (idx)
         0: return 12'h600;
         1: return 12'h800;
         2: return 12'h180;
         3: case (op)
               4'h0, 4'h1, 4'h2: return 12'h240;
               4'hE:             return 12'h011;
               default:          return 12'h000;
            endcase
         4: case (op)
               4'h0:    return 12'h120;
               4'h1:    return 12'h102;
               4'h2:    return 12'h10A;
               default: return 12'h000;
            endcase
         5: case (op)
               4'h1:    return 12'h024;
               4'h2:    return 12'h02C;
               default: return 12'h000;
            endcase
         default: return 12'h000;
      endcase
   endfunction

   // Checks the current cycle's outputs (inputs already applied), then
   // advances to just after the next rising edge.
   task automatic cyc(input logic [5:0] et, input logic [11:0] ec, input logic eh,
                      input string tag);
      logic [11:0] bus;
      #1;
      checks++;
      assert (ctrl === ec) else begin
         failures++;
         $error("FAIL %s ctrl got=%h exp=%h", tag, ctrl, ec);
      end
      checks++;
      assert (t_state === et) else begin
         failures++;
         $error("FAIL %s t_state got=%b exp=%b", tag, t_state, et);
      end
      checks++;
      assert (halted === eh) else begin
         failures++;
         $error("FAIL %s halted got=%b exp=%b", tag, halted, eh);
      end
      bus = ctrl & 12'h554;
      checks++;
      assert ($countones(bus) <= 1) else begin
         failures++;
         $error("FAIL %s bus_drivers got=%h exp=onehot0", tag, bus);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int idx;
      logic [3:0] op;
      logic [3:0] ops [7];
      ops = '{4'h0, 4'h1, 4'h2, 4'hE, 4'h5, 4'h9, 4'h3};

      // Reset: ctrl forced to 0 in the reset cycle even before state is known.
      clr_n = 1'b0; i_en = 1'b1; opcode = 4'h0;
      #2;
      checks++;
      assert (ctrl === 12'h000) else begin
         failures++;
         $error("FAIL rst_ctrl got=%h exp=000", ctrl);
      end
      @(posedge clk); #1;
      cyc(6'h01, 12'h000, 1'b0, "rst_hold");

      // LDA
      clr_n = 1'b1; opcode = 4'h0;
      cyc(6'h01, 12'h600, 1'b0, "lda_t1");
      cyc(6'h02, 12'h800, 1'b0, "lda_t2");
      cyc(6'h04, 12'h180, 1'b0, "lda_t3");
      cyc(6'h08, 12'h240, 1'b0, "lda_t4");
      cyc(6'h10, 12'h120, 1'b0, "lda_t5");
      cyc(6'h20, 12'h000, 1'b0, "lda_t6");

      // SUB
      opcode = 4'h2;
      cyc(6'h01, 12'h600, 1'b0, "sub_t1");
      cyc(6'h02, 12'h800, 1'b0, "sub_t2");
      cyc(6'h04, 12'h180, 1'b0, "sub_t3");
      cyc(6'h08, 12'h240, 1'b0, "sub_t4");
      cyc(6'h10, 12'h10A, 1'b0, "sub_t5");
      cyc(6'h20, 12'h02C, 1'b0, "sub_t6");

      // ADD with pauses in T2 and T5
      opcode = 4'h1;
      cyc(6'h01, 12'h600, 1'b0, "add_t1");
      i_en = 1'b0;
      cyc(6'h02, 12'h000, 1'b0, "pause_t2_a");
      cyc(6'h02, 12'h000, 1'b0, "pause_t2_b");
      cyc(6'h02, 12'h000, 1'b0, "pause_t2_c");
      i_en = 1'b1;
      cyc(6'h02, 12'h800, 1'b0, "add_t2");
      cyc(6'h04, 12'h180, 1'b0, "add_t3");
      cyc(6'h08, 12'h240, 1'b0, "add_t4");
      i_en = 1'b0;
      cyc(6'h10, 12'h000, 1'b0, "pause_t5_a");
      cyc(6'h10, 12'h000, 1'b0, "pause_t5_b");
      cyc(6'h10, 12'h000, 1'b0, "pause_t5_c");
      i_en = 1'b1;
      cyc(6'h10, 12'h102, 1'b0, "add_t5");
      cyc(6'h20, 12'h024, 1'b0, "add_t6");

      // ADD aborted by reset in T5: no a_load ever issued
      cyc(6'h01, 12'h600, 1'b0, "abort_t1");
      cyc(6'h02, 12'h800, 1'b0, "abort_t2");
      cyc(6'h04, 12'h180, 1'b0, "abort_t3");
      cyc(6'h08, 12'h240, 1'b0, "abort_t4");
      clr_n = 1'b0;
      cyc(6'h10, 12'h000, 1'b0, "abort_t5_rst");
      clr_n = 1'b1;
      cyc(6'h01, 12'h600, 1'b0, "abort_t1_after");

      // OUT
      opcode = 4'hE;
      cyc(6'h02, 12'h800, 1'b0, "out_t2");
      cyc(6'h04, 12'h180, 1'b0, "out_t3");
      cyc(6'h08, 12'h011, 1'b0, "out_t4");
      cyc(6'h10, 12'h000, 1'b0, "out_t5");
      cyc(6'h20, 12'h000, 1'b0, "out_t6");

      // HLT, then 20 cycles frozen with i_en toggling, then reset with i_en=0
      opcode = 4'hF;
      cyc(6'h01, 12'h600, 1'b0, "hlt_t1");
      cyc(6'h02, 12'h800, 1'b0, "hlt_t2");
      cyc(6'h04, 12'h180, 1'b0, "hlt_t3");
      cyc(6'h08, 12'h000, 1'b0, "hlt_t4");
      for (int i = 0; i < 20; i++) begin
         i_en = i[0];
         opcode = (i < 10) ? 4'hF : 4'h0;
         cyc(6'h08, 12'h000, 1'b1, "halt_hold");
      end
      clr_n = 1'b0; i_en = 1'b0;
      cyc(6'h08, 12'h000, 1'b1, "halt_rst");
      clr_n = 1'b1; i_en = 1'b1;
      cyc(6'h01, 12'h600, 1'b0, "halt_release");

      // Random sweep from a fresh T1, undefined opcodes included
      clr_n = 1'b0;
      cyc(6'h02, 12'h000, 1'b0, "sweep_rst");
      clr_n = 1'b1;
      idx = 0;
      op = 4'h0;
      for (int c = 0; c < 1000; c++) begin
         if (idx == 0) begin
            op = ops[$urandom_range(0, 6)];
            opcode = op;
         end
         i_en = ($urandom_range(0, 3) != 0);
         cyc(6'(1 << idx), i_en ? exp_word(idx, op) : 12'h000, 1'b0, "sweep");
         if (i_en) idx = (idx + 1) % 6;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout got=running exp=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
